// File: rtl/arm_mc_pkg.sv
// arm_mc_pkg: shared definitions for the multicycle ARM main sequencer.
//   statetype        - sequencer state codes (also exported on State for debug)
//   ALUSRCA_*        - ALUSrcA operand select encodings
//   ALUSRCB_*        - ALUSrcB operand select encodings
//   RESSRC_*         - ResultSrc result select encodings
//   MAXWAIT_DEFAULT  - default memory-wait budget before the watchdog faults
package arm_mc_pkg;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9,
      LINK   = 4'd10,
      FAULT  = 4'd15
   } statetype;

   localparam logic [1:0] ALUSRCA_RD1 = 2'b00;
   localparam logic [1:0] ALUSRCA_PC  = 2'b01;

   localparam logic [1:0] ALUSRCB_RD2  = 2'b00;
   localparam logic [1:0] ALUSRCB_IMM  = 2'b01;
   localparam logic [1:0] ALUSRCB_FOUR = 2'b10;
   localparam logic [1:0] ALUSRCB_ZERO = 2'b11;

   localparam logic [1:0] RESSRC_ALUOUT = 2'b00;
   localparam logic [1:0] RESSRC_DATA   = 2'b01;
   localparam logic [1:0] RESSRC_ALU    = 2'b10;

   localparam int unsigned MAXWAIT_DEFAULT = 15;

endpackage

// File: rtl/arm_mc_ctrl_if.sv
// arm_mc_ctrl_if: bundle between the main sequencer and the datapath.
//   Op, Funct, MemReady  - instruction fields and memory completion (datapath -> ctrl)
//   MemReq .. Fault      - raw control strobes (ctrl -> datapath)
//   State                - current sequencer state, debug only
// modport master: the sequencer; modport slave: the datapath / memory side.
interface arm_mc_ctrl_if;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic       MemReady;
   logic       MemReq;
   logic       AdrSrc;
   logic       IRWrite;
   logic       NextPC;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ResultSrc;
   logic       ALUOp;
   logic       RegW;
   logic       MemW;
   logic       Branch;
   logic       LinkW;
   logic       Fault;
   logic [3:0] State;

   modport master (
      input  Op, Funct, MemReady,
      output MemReq, AdrSrc, IRWrite, NextPC, ALUSrcA, ALUSrcB, ResultSrc,
             ALUOp, RegW, MemW, Branch, LinkW, Fault, State
   );

   modport slave (
      output Op, Funct, MemReady,
      input  MemReq, AdrSrc, IRWrite, NextPC, ALUSrcA, ALUSrcB, ResultSrc,
             ALUOp, RegW, MemW, Branch, LinkW, Fault, State
   );
endinterface

// File: rtl/arm_mc_waitcnt.sv
// arm_mc_waitcnt: memory-wait watchdog counter.
//   clk, reset - clock, synchronous active-high reset
//   clr        - clear the count (state change or memory ready)
//   inc        - one more cycle spent waiting on memory
//   expired    - count has reached MAXWAIT and another wait cycle is requested
module arm_mc_waitcnt #(
   parameter int unsigned MAXWAIT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int unsigned W = (MAXWAIT > 0) ? $clog2(MAXWAIT + 1) : 1;

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)      cnt_d = '0;
      else if (inc) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign expired = inc && (cnt_q == W'(MAXWAIT));

endmodule

// File: rtl/arm_mc_ctrl.sv
// arm_mc_ctrl: main sequencer FSM for the multicycle ARMv4-subset core.
//   clk, reset - clock, synchronous active-high reset
//   mc         - arm_mc_ctrl_if.master: Op/Funct/MemReady in, raw control strobes,
//                sticky Fault and debug State out
// Strobes are ungated; condition logic downstream qualifies RegW/MemW/Branch/LinkW.
// Build option: define ARM_MC_BL_EN to add the LINK state for BL (Op=10, Funct[4]=1).
module arm_mc_ctrl
   import arm_mc_pkg::*;
#(
   parameter int unsigned MAXWAIT = MAXWAIT_DEFAULT
) (
   input logic           clk,
   input logic           reset,
   arm_mc_ctrl_if.master mc
);

   logic [3:0] state_q, state_d, state_nxt;
   logic       wait_st, inc, clr, expired;

   // Funct[3:1] (and Funct[4] without BL) carry ALU/memory detail decoded elsewhere.
   logic unused_funct;
   assign unused_funct = ^mc.Funct[4:1];

   always_comb begin
      state_nxt = FETCH;
      case (state_q)
         FETCH:  state_nxt = mc.MemReady ? DECODE : FETCH;
         DECODE: begin
            case (mc.Op)
               2'b01:   state_nxt = MEMADR;
               2'b00:   state_nxt = mc.Funct[5] ? EXECI : EXECR;
`ifdef ARM_MC_BL_EN
               2'b10:   state_nxt = mc.Funct[4] ? LINK : BRANCH;
`else
               2'b10:   state_nxt = BRANCH;
`endif
               default: state_nxt = FETCH;
            endcase
         end
         MEMADR: state_nxt = mc.Funct[0] ? MEMRD : MEMWR;
         MEMRD:  state_nxt = mc.MemReady ? MEMWB : MEMRD;
         MEMWB:  state_nxt = FETCH;
         MEMWR:  state_nxt = mc.MemReady ? FETCH : MEMWR;
         EXECR:  state_nxt = ALUWB;
         EXECI:  state_nxt = ALUWB;
         ALUWB:  state_nxt = FETCH;
         BRANCH: state_nxt = FETCH;
`ifdef ARM_MC_BL_EN
         LINK:   state_nxt = BRANCH;
`endif
         FAULT:  state_nxt = FAULT;
         default: state_nxt = FETCH;
      endcase
   end

   assign wait_st = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
   assign inc     = wait_st && !mc.MemReady;
   // Watchdog expiry overrides every other transition.
   assign state_d = expired ? FAULT : state_nxt;
   assign clr     = mc.MemReady || (state_d != state_q);

   arm_mc_waitcnt #(
      .MAXWAIT (MAXWAIT)
   ) u_waitcnt (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr),
      .inc     (inc),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   logic       memreq, adrsrc, irwrite, aluop, regw, memw, branch, linkw, fault;
   logic [1:0] alusrca, alusrcb, resultsrc;

   // Moore decode; everything is held at 0 while reset is asserted.
   always_comb begin
      memreq    = 1'b0;
      adrsrc    = 1'b0;
      alusrca   = ALUSRCA_RD1;
      alusrcb   = ALUSRCB_RD2;
      resultsrc = RESSRC_ALUOUT;
      aluop     = 1'b0;
      regw      = 1'b0;
      memw      = 1'b0;
      branch    = 1'b0;
      linkw     = 1'b0;
      fault     = 1'b0;
      if (!reset) begin
         case (state_q)
            FETCH: begin
               memreq    = 1'b1;
               alusrca   = ALUSRCA_PC;
               alusrcb   = ALUSRCB_FOUR;
               resultsrc = RESSRC_ALU;
            end
            DECODE: begin
               alusrca   = ALUSRCA_PC;
               alusrcb   = ALUSRCB_FOUR;
               resultsrc = RESSRC_ALU;
            end
            MEMADR: alusrcb = ALUSRCB_IMM;
            MEMRD: begin
               memreq = 1'b1;
               adrsrc = 1'b1;
            end
            MEMWB: begin
               resultsrc = RESSRC_DATA;
               regw      = 1'b1;
            end
            MEMWR: begin
               memreq = 1'b1;
               adrsrc = 1'b1;
               memw   = 1'b1;
            end
            EXECR: aluop = 1'b1;
            EXECI: begin
               alusrcb = ALUSRCB_IMM;
               aluop   = 1'b1;
            end
            ALUWB: regw = 1'b1;
            BRANCH: begin
               alusrcb   = ALUSRCB_IMM;
               resultsrc = RESSRC_ALU;
               branch    = 1'b1;
            end
`ifdef ARM_MC_BL_EN
            LINK: begin
               alusrca   = ALUSRCA_PC;
               alusrcb   = ALUSRCB_ZERO;
               resultsrc = RESSRC_ALU;
               linkw     = 1'b1;
            end
`endif
            FAULT: fault = 1'b1;
            default: ;
         endcase
      end
   end

   // IRWrite/NextPC are Mealy: the instruction is latched in the cycle memory answers.
   assign irwrite = !reset && (state_q == FETCH) && mc.MemReady;

   assign mc.MemReq    = memreq;
   assign mc.AdrSrc    = adrsrc;
   assign mc.IRWrite   = irwrite;
   assign mc.NextPC    = irwrite;
   assign mc.ALUSrcA   = alusrca;
   assign mc.ALUSrcB   = alusrcb;
   assign mc.ResultSrc = resultsrc;
   assign mc.ALUOp     = aluop;
   assign mc.RegW      = regw;
   assign mc.MemW      = memw;
   assign mc.Branch    = branch;
   assign mc.LinkW     = linkw;
   assign mc.Fault     = fault;
   assign mc.State     = state_q;

endmodule

// File: tb/tb_arm_mc_ctrl.sv
// tb_arm_mc_ctrl: scoreboard bench for arm_mc_ctrl (MAXWAIT=15).
// Each step drives inputs, pushes the expected state/strobe vector, then pops and
// compares at the falling edge.
module tb_arm_mc_ctrl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   arm_mc_ctrl_if mc ();

   arm_mc_ctrl #(
      .MAXWAIT (15)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .mc    (mc)
   );

   typedef struct {
      logic [3:0]  st;
      logic [15:0] out;
   } exp_t;

   exp_t  sb[$];
   int    errors = 0;
   int    checks = 0;
   string phase  = "init";

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference strobes, bit order:
   // MemReq AdrSrc IRWrite NextPC ALUSrcA[2] ALUSrcB[2] ResultSrc[2] ALUOp RegW MemW Branch
   // LinkW Fault
   function automatic logic [15:0] exp_out(input logic [3:0] st, input logic mr,
                                           input logic rst);
      logic [15:0] o;
      o = '0;
      if (rst) return o;
      case (st)
         4'd0: begin
            o[15] = 1'b1; o[13] = mr; o[12] = mr;
            o[11:10] = 2'b01; o[9:8] = 2'b10; o[7:6] = 2'b10;
         end
         4'd1: begin o[11:10] = 2'b01; o[9:8] = 2'b10; o[7:6] = 2'b10; end
         4'd2: o[9:8] = 2'b01;
         4'd3: begin o[15] = 1'b1; o[14] = 1'b1; end
         4'd4: begin o[7:6] = 2'b01; o[4] = 1'b1; end
         4'd5: begin o[15] = 1'b1; o[14] = 1'b1; o[3] = 1'b1; end
         4'd6: o[5] = 1'b1;
         4'd7: begin o[9:8] = 2'b01; o[5] = 1'b1; end
         4'd8: o[4] = 1'b1;
         4'd9: begin o[9:8] = 2'b01; o[7:6] = 2'b10; o[2] = 1'b1; end
         4'd10: begin
            o[11:10] = 2'b01; o[9:8] = 2'b11; o[7:6] = 2'b10; o[1] = 1'b1;
         end
         4'd15: o[0] = 1'b1;
         default: ;
      endcase
      return o;
   endfunction

   task automatic step(input logic rst, input logic mr, input logic [3:0] es);
      exp_t        e;
      logic [15:0] got;
      reset       = rst;
      mc.MemReady = mr;
      e.st  = es;
      e.out = exp_out(es, mr, rst);
      sb.push_back(e);
      @(negedge clk);
      e   = sb.pop_front();
      got = {mc.MemReq, mc.AdrSrc, mc.IRWrite, mc.NextPC, mc.ALUSrcA, mc.ALUSrcB,
             mc.ResultSrc, mc.ALUOp, mc.RegW, mc.MemW, mc.Branch, mc.LinkW, mc.Fault};
      if (!$isunknown(e.st)) check({phase, ".state"}, {28'b0, mc.State}, {28'b0, e.st});
      check({phase, ".strobes"}, {16'b0, got}, {16'b0, e.out});
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input string name, input logic [1:0] op, input logic [5:0] funct);
      phase    = name;
      mc.Op    = op;
      mc.Funct = funct;
   endtask

   // ADD r2,r0,r1 with memory always ready: 0,1,6,8.
   task automatic run_add(input string name);
      set_instr(name, 2'b00, 6'b001000);
      step(0, 1, 4'd0);
      step(0, 1, 4'd1);
      step(0, 1, 4'd6);
      step(0, 1, 4'd8);
   endtask

   initial begin
      mc.Op       = 2'b00;
      mc.Funct    = 6'b000000;
      mc.MemReady = 1'b0;
      reset       = 1'b1;
      #1;

      phase = "reset";
      step(1, 1, 4'bxxxx);
      step(1, 1, 4'd0);

      run_add("add");

      set_instr("addi", 2'b00, 6'b101000);
      step(0, 1, 4'd0);
      step(0, 1, 4'd1);
      step(0, 1, 4'd7);
      step(0, 1, 4'd8);

      // LDR, MemReady low for 3 cycles in MEMRD.
      set_instr("ldr", 2'b01, 6'b011001);
      step(0, 1, 4'd0);
      step(0, 1, 4'd1);
      step(0, 1, 4'd2);
      for (int i = 0; i < 3; i++) step(0, 0, 4'd3);
      step(0, 1, 4'd3);
      step(0, 1, 4'd4);

      // STR, MemReady low for 2 cycles in MEMWR.
      set_instr("str", 2'b01, 6'b011000);
      step(0, 1, 4'd0);
      step(0, 1, 4'd1);
      step(0, 1, 4'd2);
      step(0, 0, 4'd5);
      step(0, 0, 4'd5);
      step(0, 1, 4'd5);

      set_instr("b", 2'b10, 6'b100000);
      step(0, 1, 4'd0);
      step(0, 1, 4'd1);
      step(0, 1, 4'd9);

      set_instr("bl", 2'b10, 6'b110000);
      step(0, 1, 4'd0);
      step(0, 1, 4'd1);
`ifdef ARM_MC_BL_EN
      step(0, 1, 4'd10);
`endif
      step(0, 1, 4'd9);

      set_instr("nop", 2'b11, 6'b000000);
      step(0, 1, 4'd0);
      step(0, 1, 4'd1);

      // Fetch timeout: 16 stalled cycles, then sticky FAULT.
      set_instr("fetch_to", 2'b00, 6'b001000);
      for (int i = 0; i < 16; i++) step(0, 0, 4'd0);
      for (int i = 0; i < 100; i++) step(0, 1'(i % 2), 4'd15);

      phase = "rst_fault";
      step(1, 1, 4'd15);
      run_add("add_after_fault");

      // Ready arrives in the last tolerated cycle: no fault.
      set_instr("fetch_edge", 2'b00, 6'b001000);
      for (int i = 0; i < 15; i++) step(0, 0, 4'd0);
      step(0, 1, 4'd0);
      step(0, 1, 4'd1);
      step(0, 1, 4'd6);
      step(0, 1, 4'd8);

      // Timeout while waiting on a load.
      set_instr("ldr_to", 2'b01, 6'b011001);
      step(0, 1, 4'd0);
      step(0, 1, 4'd1);
      step(0, 1, 4'd2);
      for (int i = 0; i < 16; i++) step(0, 0, 4'd3);
      step(0, 0, 4'd15);
      step(0, 1, 4'd15);
      phase = "rst_fault2";
      step(1, 0, 4'd15);

      // Reset mid-store drops MemW in the same cycle.
      set_instr("str_rst", 2'b01, 6'b011000);
      step(0, 1, 4'd0);
      step(0, 1, 4'd1);
      step(0, 1, 4'd2);
      step(0, 0, 4'd5);
      step(1, 0, 4'd5);
      run_add("add_after_str_rst");
      phase = "final";
      step(0, 1, 4'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
